// File: rtl/hazard_scoreboard.sv
// Register-file hazard scoreboard: tracks in-flight producers per register,
// selects a bypass stage for each decoded source operand, and stalls ID
// while a needed result is not yet available.
module hazard_scoreboard #(
  parameter  int NSRC  = 2,
  parameter  int DEPTH = 4,
  parameter  int KEEP  = 2,
  localparam int AW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_rfwr,
  input  logic [4:0]           id_rd,
  input  logic [AW-1:0]        id_lat,
  input  logic [5*NSRC-1:0]    id_src,
  input  logic [NSRC-1:0]      id_src_en,
  input  logic                 pipe_hold,
  input  logic                 flush,
  output logic                 stall,
  output logic [AW*NSRC-1:0]   fwd_sel
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] KEEP_A  = AW'(KEEP);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  logic [31:0]   pend, pend_nxt;
  logic [AW-1:0] age [32];
  logic [AW-1:0] age_nxt [32];
  logic [AW-1:0] lat [32];
  logic [AW-1:0] lat_nxt [32];

  logic [AW-1:0] lat_clamped;
  logic [4:0]    src;
  logic          stall_any;
  logic          issue;

  // Clamp the requested bypass latency into 1..DEPTH
  always_comb begin
    lat_clamped = id_lat;
    if (id_lat == '0)
      lat_clamped = ONE_A;
    else if (id_lat > DEPTH_A)
      lat_clamped = DEPTH_A;
  end

  // Per-port bypass selection and hazard detection
  always_comb begin
    fwd_sel   = '0;
    stall_any = 1'b0;
    src       = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      src = id_src[5*k +: 5];
      if (id_src_en[k] && (src != '0) && pend[src]) begin
        if (age[src] >= lat[src])
          fwd_sel[AW*k +: AW] = age[src];
        else
          stall_any = 1'b1;
      end
    end
  end

  assign stall = id_valid & ~flush & stall_any;
  assign issue = id_valid & id_rfwr & ~stall & ~pipe_hold & ~flush & (id_rd != '0);

  // Table update: flush clears young entries, survivors age unless held;
  // issue is applied last so a same-edge retire of id_rd is overridden.
  always_comb begin
    pend_nxt = pend;
    age_nxt  = age;
    lat_nxt  = lat;
    pend_nxt[0] = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      if (pend[r]) begin
        if (flush && (age[r] < KEEP_A)) begin
          pend_nxt[r] = 1'b0;
          age_nxt[r]  = '0;
          lat_nxt[r]  = '0;
        end else if (!pipe_hold) begin
          if (age[r] >= DEPTH_A) begin
            pend_nxt[r] = 1'b0;
            age_nxt[r]  = '0;
            lat_nxt[r]  = '0;
          end else begin
            age_nxt[r] = age[r] + ONE_A;
          end
        end
      end
      if (issue && (id_rd == 5'(r))) begin
        pend_nxt[r] = 1'b1;
        age_nxt[r]  = ONE_A;
        lat_nxt[r]  = lat_clamped;
      end
    end
  end

  // Scoreboard state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int unsigned r = 0; r < 32; r++) begin
        age[r] <= '0;
        lat[r] <= '0;
      end
    end else begin
      pend <= pend_nxt;
      for (int unsigned r = 0; r < 32; r++) begin
        age[r] <= age_nxt[r];
        lat[r] <= lat_nxt[r];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, an
// asynchronous-reset sequence, and randomized traffic against a queue model.
module tb_hazard_scoreboard;

  localparam int NSRC  = 2;
  localparam int DEPTH = 4;
  localparam int KEEP  = 2;
  localparam int AW    = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               id_valid, id_rfwr, pipe_hold, flush;
  logic [4:0]         id_rd;
  logic [AW-1:0]      id_lat;
  logic [5*NSRC-1:0]  id_src;
  logic [NSRC-1:0]    id_src_en;
  logic               stall;
  logic [AW*NSRC-1:0] fwd_sel;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .KEEP(KEEP)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rfwr(id_rfwr),
    .id_rd(id_rd), .id_lat(id_lat), .id_src(id_src), .id_src_en(id_src_en),
    .pipe_hold(pipe_hold), .flush(flush), .stall(stall), .fwd_sel(fwd_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit w; int rd; int lat; int s0; int s1; bit e0; bit e1;
    bit hold; bit fl; int st; int f0; int f1;
  } vec_t;

  typedef struct { int rd; int age; int lat; } prod_t;
  prod_t q[$];

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid  = t.v;
    id_rfwr   = t.w;
    id_rd     = 5'(t.rd);
    id_lat    = AW'(t.lat);
    id_src    = {5'(t.s1), 5'(t.s0)};
    id_src_en = {t.e1, t.e0};
    pipe_hold = t.hold;
    flush     = t.fl;
  endtask

  function automatic vec_t mk(bit v, bit w, int rd, int lat, int s0, bit e0,
                              int s1, bit e1, bit hold, bit fl,
                              int st, int f0, int f1);
    vec_t t;
    t.v = v; t.w = w; t.rd = rd; t.lat = lat; t.s0 = s0; t.e0 = e0;
    t.s1 = s1; t.e1 = e1; t.hold = hold; t.fl = fl;
    t.st = st; t.f0 = f0; t.f1 = f1;
    return t;
  endfunction

  // Reference model: list of in-flight producers with their age in stages
  function automatic void model_out(input vec_t t, output int st, output int f0, output int f1);
    int s [2];
    bit e [2];
    int f [2];
    bit any;
    s[0] = t.s0; s[1] = t.s1; e[0] = t.e0; e[1] = t.e1;
    any = 0;
    for (int k = 0; k < 2; k++) begin
      f[k] = 0;
      if (e[k] && s[k] != 0)
        foreach (q[i])
          if (q[i].rd == s[k]) begin
            if (q[i].age >= q[i].lat) f[k] = q[i].age;
            else any = 1;
          end
    end
    st = (t.v && !t.fl && any) ? 1 : 0;
    f0 = f[0]; f1 = f[1];
  endfunction

  function automatic void model_step(input vec_t t, input int st);
    prod_t nq[$];
    int lat_c;
    bit iss;
    iss = t.v && t.w && (st == 0) && !t.hold && !t.fl && (t.rd != 0);
    foreach (q[i]) begin
      prod_t e;
      e = q[i];
      if (t.fl && e.age < KEEP) continue;
      if (!t.hold) begin
        e.age++;
        if (e.age > DEPTH) continue;
      end
      if (iss && e.rd == t.rd) continue;
      nq.push_back(e);
    end
    if (iss) begin
      lat_c = (t.lat == 0) ? 1 : (t.lat > DEPTH ? DEPTH : t.lat);
      nq.push_back('{rd: t.rd, age: 1, lat: lat_c});
    end
    q = nq;
  endfunction

  function automatic int fw0();
    logic [AW-1:0] x;
    x = fwd_sel[AW-1:0];
    return int'(x);
  endfunction

  function automatic int fw1();
    logic [AW-1:0] x;
    x = fwd_sel[2*AW-1:AW];
    return int'(x);
  endfunction

  initial begin
    vec_t idle, t;
    int est, ef0, ef1;
    idle = mk(0,0,0,0, 0,0, 0,0, 0,0, 0,0,0);

    // load-use: r5 lat 3
    tbl.push_back(mk(1,1,5,3, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 5,1, 0,0, 0,0, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 5,1, 0,0, 0,0, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 5,1, 0,0, 0,0, 0,3,0));
    tbl.push_back(mk(1,0,0,0, 5,1, 0,0, 0,0, 0,4,0));
    tbl.push_back(mk(1,0,0,0, 5,1, 0,0, 0,0, 0,0,0));
    // ALU chain: r8 lat 1 read on port 1
    tbl.push_back(mk(1,1,8,1, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 8,1, 0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 8,1, 0,0, 0,0,2));
    tbl.push_back(idle);
    tbl.push_back(idle);
    // overwrite: r3 lat 2 then r3 lat 1
    tbl.push_back(mk(1,1,3,2, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,1,3,1, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 3,1, 0,0, 0,0, 0,1,0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(idle);
    // hold: r7 lat 3, four held cycles, still age 1 afterwards
    tbl.push_back(mk(1,1,7,3, 0,0, 0,0, 0,0, 0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0,0, 7,1, 0,0, 1,0, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 7,1, 0,0, 0,0, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 7,1, 0,0, 0,0, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 7,1, 0,0, 0,0, 0,3,0));
    tbl.push_back(idle);
    // flush: r10 at age 3, r11 at age 1
    tbl.push_back(mk(1,1,10,1, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(idle);
    tbl.push_back(mk(1,1,11,1, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 10,1, 11,1, 0,1, 0,3,1));
    tbl.push_back(mk(1,0,0,0, 10,1, 11,1, 0,0, 0,4,0));
    tbl.push_back(mk(1,0,0,0, 10,1, 11,1, 0,0, 0,0,0));
    // r0 never tracked; latency 0 treated as 1
    tbl.push_back(mk(1,1,0,1, 0,0, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,1,9,0, 0,1, 0,0, 0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,1, 9,1, 0,0, 0,0,1));

    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", int'(stall), 0);
    check("reset_fwd", int'(fwd_sel), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("vec%0d_stall", i), int'(stall), tbl[i].st);
      check($sformatf("vec%0d_fwd0", i), fw0(), tbl[i].f0);
      check($sformatf("vec%0d_fwd1", i), fw1(), tbl[i].f1);
    end

    // asynchronous reset between edges, then a fresh issue
    @(negedge clk);
    drive(mk(1,1,5,3, 0,0, 0,0, 0,0, 0,0,0));
    @(negedge clk);
    drive(mk(1,0,0,0, 5,1, 0,0, 0,0, 1,0,0));
    #1;
    check("pre_rst_stall", int'(stall), 1);
    rst = 1'b1;
    #1;
    check("async_rst_stall", int'(stall), 0);
    check("async_rst_fwd", int'(fwd_sel), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1,1,5,1, 0,0, 0,0, 0,0, 0,0,0));
    #1;
    check("post_rst_issue_stall", int'(stall), 0);
    @(negedge clk);
    drive(mk(1,0,0,0, 5,1, 0,0, 0,0, 0,1,0));
    #1;
    check("post_rst_fwd0", fw0(), 1);
    check("post_rst_stall", int'(stall), 0);

    // randomized traffic against the model, starting from an empty table
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      t.v    = ($urandom_range(0, 7) != 0);
      t.w    = ($urandom_range(0, 2) != 0);
      t.rd   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      t.lat  = $urandom_range(0, (1 << AW) - 1);
      t.s0   = $urandom_range(0, 7);
      t.s1   = $urandom_range(0, 7);
      t.e0   = ($urandom_range(0, 3) != 0);
      t.e1   = ($urandom_range(0, 3) != 0);
      t.hold = ($urandom_range(0, 5) == 0);
      t.fl   = ($urandom_range(0, 9) == 0);
      drive(t);
      model_out(t, est, ef0, ef1);
      #1;
      check("rand_stall", int'(stall), est);
      check("rand_fwd0", fw0(), ef0);
      check("rand_fwd1", fw1(), ef1);
      @(posedge clk);
      model_step(t, est);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
